// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, shift counter, period tick and all-zero lock-up detection
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   sh_en    in   1      shift enable, one shift per cycle while high
//   load     in   1      synchronous load strobe (wins over sh_en)
//   load_val in   WIDTH  value captured on load
//   q_out    out  WIDTH  current LFSR state
//   cnt_out  out  CNT_W  shifts since the last reset, load or wrap
//   max_tick out  1      one-cycle pulse after the PERIOD-th shift
//   lockup   out  1      high while the state is all-zero
//
// Build option: define LFSR_LOCKUP_RECOVER_EN so that a shift out of the
// all-zero state reloads SEED; otherwise the all-zero state is absorbing.
module lfsr_gen #(
  parameter int unsigned             WIDTH  = 17,
  parameter logic [WIDTH-1:0]        TAPS   = WIDTH'(17'h12000),
  parameter logic [WIDTH-1:0]        SEED   = WIDTH'(17'h00028),
  parameter int unsigned             PERIOD = 131071,
  parameter int unsigned             CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             max_tick,
  output logic             lockup
);
  logic             fb;
  logic             wrap;
  logic             tick_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  always_comb begin
    fb       = ^(q_out & TAPS);
`ifdef LFSR_LOCKUP_RECOVER_EN
    shifted  = (q_out == '0) ? SEED : {q_out[WIDTH-2:0], fb};
`else
    shifted  = {q_out[WIDTH-2:0], fb};
`endif
    wrap     = cnt_out == CNT_W'(PERIOD - 1);
    q_nxt    = load ? load_val : sh_en ? shifted : q_out;
    cnt_nxt  = load ? '0 : sh_en ? (wrap ? '0 : cnt_out + 1'b1) : cnt_out;
    tick_nxt = !load && sh_en && wrap;
  end
  // lockup is derived from the next state so it moves on the same edge as q_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out    <= SEED;
      cnt_out  <= '0;
      max_tick <= 1'b0;
      lockup   <= 1'b0;
    end else begin
      q_out    <= q_nxt;
      cnt_out  <= cnt_nxt;
      max_tick <= tick_nxt;
      lockup   <= q_nxt == '0;
    end
  end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed self-checking bench for lfsr_gen (default and 4-bit configurations)
module tb_lfsr_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sh_en, load, sh4, ld4;
  logic [16:0] lv, q;
  logic [3:0]  lv4, q4;
  logic [31:0] cnt, cnt4;
  logic        tick, lock, tick4, lock4;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp4 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .sh_en(sh_en), .load(load), .load_val(lv),
    .q_out(q), .cnt_out(cnt), .max_tick(tick), .lockup(lock)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .PERIOD(15), .CNT_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .sh_en(sh4), .load(ld4), .load_val(lv4),
    .q_out(q4), .cnt_out(cnt4), .max_tick(tick4), .lockup(lock4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; sh_en = 1'b0; load = 1'b0; lv = '0;
    sh4 = 1'b0; ld4 = 1'b0; lv4 = '0;
    cyc(); cyc();
    chk("rst_q", q, 32'h28);
    chk("rst_cnt", cnt, 0);
    chk("rst_tick", tick, 0);
    chk("rst_lock", lock, 0);
    chk("rst_q4", q4, 1);
    rst_n = 1'b1; sh_en = 1'b1;
    cyc();
    sh_en = 1'b0;
    chk("shift1_q", q, 32'h50);
    chk("shift1_cnt", cnt, 1);
    load = 1'b1; lv = 17'h10000;
    cyc();
    load = 1'b0;
    chk("ld10000_q", q, 32'h10000);
    chk("ld10000_cnt", cnt, 0);
    sh_en = 1'b1;
    cyc();
    sh_en = 1'b0;
    chk("sh10000_q", q, 32'h00001);
    load = 1'b1; lv = 17'h12000;
    cyc();
    load = 1'b0; sh_en = 1'b1;
    cyc();
    sh_en = 1'b0;
    chk("sh12000_q", q, 32'h04000);
    chk("sh12000_cnt", cnt, 1);
    load = 1'b1; sh_en = 1'b1; lv = 17'h0ABCD;
    cyc();
    load = 1'b0; sh_en = 1'b0;
    chk("ldsh_q", q, 32'h0ABCD);
    chk("ldsh_cnt", cnt, 0);
    chk("ldsh_tick", tick, 0);
    load = 1'b1; lv = '0;
    cyc();
    load = 1'b0;
    chk("ld0_q", q, 0);
    chk("ld0_lock", lock, 1);
    sh_en = 1'b1;
    cyc();
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("z1_q", q, 32'h28);
    chk("z1_lock", lock, 0);
`else
    chk("z1_q", q, 0);
    chk("z1_lock", lock, 1);
`endif
    cyc(); cyc();
    sh_en = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("z3_q", q, 32'hA0);
    chk("z3_lock", lock, 0);
`else
    chk("z3_q", q, 0);
    chk("z3_lock", lock, 1);
`endif
    chk("z3_cnt", cnt, 3);
    sh_en = 1'b1;
    repeat (4) cyc();
    sh_en = 1'b0;
    chk("pre_rst_cnt", cnt, 7);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_q", q, 32'h28);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_tick", tick, 0);
    #2 rst_n = 1'b1;
    sh_en = 1'b1;
    cyc();
    sh_en = 1'b0;
    chk("post_rst_q", q, 32'h50);
    chk("post_rst_cnt", cnt, 1);
    sh4 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 15; k++) begin
        cyc();
        chk("w4_q", q4, exp4[k]);
        chk("w4_cnt", cnt4, (k + 1) % 15);
        chk("w4_tick", tick4, k == 14);
      end
    end
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      sh4 = c[0];
      cyc();
      if (c[0]) n++;
      chk("tog_tick", tick4, c[0] && n == 15);
    end
    sh4 = 1'b0;
    chk("tog_q", q4, 1);
    chk("tog_cnt", cnt4, 0);
    sh4 = 1'b1;
    repeat (14) cyc();
    chk("prewrap_cnt", cnt4, 14);
    ld4 = 1'b1; lv4 = 4'h5;
    cyc();
    ld4 = 1'b0; sh4 = 1'b0;
    chk("ldwrap_q", q4, 5);
    chk("ldwrap_cnt", cnt4, 0);
    chk("ldwrap_tick", tick4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
